redirect_sequencer: RTL and testbench
=====================================

# redirect_sequencer

Fetch-redirect sequencer between the decoder, the ROB commit port and the fetch PC register. It accepts three classes of PC redirect: decode-time taken branch/jump, jump-register resolved at commit, and branch-mispredict recovery at commit. It sequences each around its MIPS delay slot and emits a single registered load-PC/flush pulse per redirect. Mispredict recovery always preempts pending decode-time work.

## Interface
- ADDR_WIDTH, 32, PC width
- CNT_WIDTH, 16, statistics counter width
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- dec_redir_valid  in  1  decoder accepted (valid & !stall) a predicted-taken branch or direct jump
- dec_redir_target  in  ADDR_WIDTH  its target
- dec_jr_valid  in  1  decoder accepted a jump-register
- slot_accept  in  1  decoder accepted the next valid instruction (delay slot)
- jr_commit_valid  in  1  ROB committed the jump-register
- jr_commit_target  in  ADDR_WIDTH  resolved jr target
- mispredict_valid  in  1  ROB committed a mispredicted branch
- mispredict_target  in  ADDR_WIDTH  recovery PC
- commit_valid  in  1  ROB committed any instruction this cycle
- load_pc_we  out  1  one-cycle PC load pulse
- load_pc_new_pc  out  ADDR_WIDTH  PC to load, valid with load_pc_we
- flush  out  1  decode flush, identical timing to load_pc_we
- jr_stall  out  1  hold decode while jr target unresolved
- busy  out  1  state != IDLE
- redirect_count  out  CNT_WIDTH  load_pc_we pulses, wraps
- mispredict_count  out  CNT_WIDTH  accepted mispredicts, saturates at all-ones

## Operation
- States: IDLE, WAIT_SLOT, WAIT_SLOT_JR, WAIT_JR_TARGET, WAIT_RECOVER.
- IDLE: dec_redir_valid -> latch target, WAIT_SLOT. Otherwise dec_jr_valid -> WAIT_SLOT_JR. dec_redir_valid has priority if both are set.
- WAIT_SLOT: slot_accept -> fire latched target, IDLE.
- WAIT_SLOT_JR: jr_commit_valid -> latch target, set jr_pending. slot_accept -> if jr_pending or jr_commit_valid the same cycle, fire target and go to IDLE; else WAIT_JR_TARGET with jr_stall=1.
- WAIT_JR_TARGET: jr_commit_valid -> fire jr_commit_target, clear jr_stall, IDLE.
- Mispredict, from any state except WAIT_RECOVER:
  - latch mispredict_target, clear jr_stall and jr_pending, increment mispredict_count, WAIT_RECOVER.
  - Any pending decode/jr redirect is discarded.
- WAIT_RECOVER:
  - commit_valid (delay slot committed) -> fire, IDLE.
  - Further mispredict_valid is ignored; the younger branch is squashed by the flush.
- "Fire" means: next cycle load_pc_we=flush=1 with the target, and redirect_count increments.
- During any cycle with flush=1, dec_redir_valid, dec_jr_valid and slot_accept are ignored, because decode is being flushed. mispredict_valid is still honoured.
- IDLE with mispredict_valid and dec_redir_valid in the same cycle: mispredict wins.

## Timing
- All outputs are registered. Reset values: load_pc_we=0, load_pc_new_pc=0, flush=0, jr_stall=0, busy=0, both counters=0, state=IDLE, jr_pending=0.
- Decode redirect: dec_redir_valid at cycle N, slot_accept at cycle M>N -> pulse at M+1. If slot_accept is asserted in cycle N, it is the redirecting instruction itself and is not treated as the slot.
- JR: jr_stall rises at slot_accept+1 and falls in the same cycle that the pulse is driven (jr_commit_valid+1).
- Mispredict: pulse at first commit_valid after the mispredict cycle, +1. A commit_valid in the mispredict cycle itself does not count.
- Pulse width is exactly 1 cycle. Back-to-back redirects are possible: new request accepted in the cycle after the pulse.
- rst mid-operation: immediate return to reset values; no pulse is emitted for a pending redirect.

## Structure
- mips_core_pkg: ADDR_WIDTH, redirect_state_e enum.
- Single module. One natural sub-module, stat_counter (wrap/saturate selectable), instantiated twice.

## Test plan
- Taken branch:
  - Stimulus: dec_redir_valid, target 0x0040_0100 at cycle 2; slot_accept at cycle 5.
  - Response: load_pc_we=flush=1 with 0x0040_0100 at cycle 6 only; redirect_count=1.
- JR, target late:
  - Stimulus: dec_jr_valid at cycle 1, slot_accept at cycle 3, jr_commit_valid with 0x0040_2000 at cycle 10.
  - Response: jr_stall=1 for cycles 4..10; pulse at cycle 11.
- JR, target early:
  - Stimulus: jr_commit_valid 0x0040_3000 at cycle 4 in WAIT_SLOT_JR, slot_accept at cycle 6.
  - Response: pulse at cycle 7; jr_stall never asserts.
- Mispredict preempting a pending branch:
  - Stimulus: in WAIT_SLOT, mispredict_valid 0x0040_0444 at cycle 3, commit_valid at cycles 3 and 5.
  - Response: single pulse 0x0040_0444 at cycle 6; mispredict_count=1; the branch target is never emitted.
- Input masking during flush:
  - Stimulus: dec_redir_valid asserted in the flush cycle.
  - Response: ignored; state stays IDLE.
- Reset in WAIT_JR_TARGET:
  - Stimulus: assert rst asynchronously between clock edges.
  - Response: jr_stall=0 and busy=0 immediately; no pulse after release.
- Saturation:
  - Stimulus: CNT_WIDTH=2 with 5 mispredicts.
  - Response: mispredict_count=3.

Source files
------------

// File: rtl/redirect_sequencer_pkg.sv
// Shared definitions for the fetch-redirect sequencer: PC width and FSM encoding.
package redirect_sequencer_pkg;

    localparam int ADDR_WIDTH = 32;

    typedef logic [2:0] redirect_state_t;

    localparam logic [2:0] ST_IDLE           = 3'd0;
    localparam logic [2:0] ST_WAIT_SLOT      = 3'd1;
    localparam logic [2:0] ST_WAIT_SLOT_JR   = 3'd2;
    localparam logic [2:0] ST_WAIT_JR_TARGET = 3'd3;
    localparam logic [2:0] ST_WAIT_RECOVER   = 3'd4;

endpackage

// File: rtl/redirect_sequencer_if.sv
// Decoder / ROB / fetch-PC signal bundle for the redirect sequencer.
interface redirect_sequencer_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  dec_redir_valid;
    logic [ADDR_WIDTH-1:0] dec_redir_target;
    logic                  dec_jr_valid;
    logic                  slot_accept;
    logic                  jr_commit_valid;
    logic [ADDR_WIDTH-1:0] jr_commit_target;
    logic                  mispredict_valid;
    logic [ADDR_WIDTH-1:0] mispredict_target;
    logic                  commit_valid;
    logic                  load_pc_we;
    logic [ADDR_WIDTH-1:0] load_pc_new_pc;
    logic                  flush;
    logic                  jr_stall;
    logic                  busy;

    // Pipeline side: drives requests, observes the redirect pulse.
    modport master (
        output dec_redir_valid, dec_redir_target, dec_jr_valid, slot_accept,
               jr_commit_valid, jr_commit_target, mispredict_valid,
               mispredict_target, commit_valid,
        input  load_pc_we, load_pc_new_pc, flush, jr_stall, busy
    );

    // Sequencer side.
    modport slave (
        input  dec_redir_valid, dec_redir_target, dec_jr_valid, slot_accept,
               jr_commit_valid, jr_commit_target, mispredict_valid,
               mispredict_target, commit_valid,
        output load_pc_we, load_pc_new_pc, flush, jr_stall, busy
    );
endinterface

// File: rtl/redirect_sequencer_stat_counter.sv
// Statistics counter that either wraps or saturates at all-ones.
module stat_counter #(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    // Advance on inc; a saturating counter holds once it reaches all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            if (!SATURATE || (count != {WIDTH{1'b1}})) begin
                count <= count + 1'b1;
            end
        end
    end
endmodule

// File: rtl/redirect_sequencer.sv
// Fetch-redirect sequencer: orders decode, jump-register and mispredict
// redirects around their delay slot and emits one load-PC/flush pulse each.
module redirect_sequencer
    import redirect_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    redirect_sequencer_if.slave  bus,
    output logic [CNT_WIDTH-1:0] redirect_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);
    redirect_state_t       state, next_state;
    logic [ADDR_WIDTH-1:0] target_q, next_target;
    logic                  jr_pending, next_jr_pending;
    logic                  jr_stall_q, next_jr_stall;
    logic                  load_pc_we_q, flush_q, busy_q;
    logic [ADDR_WIDTH-1:0] new_pc_q;
    logic                  fire;
    logic [ADDR_WIDTH-1:0] fire_pc;
    logic                  mis_inc;
    logic                  decode_ok;

    // Next-state logic; an accepted mispredict overrides everything else and
    // decode-side inputs are disregarded while decode is being flushed.
    always_comb begin
        next_state      = state;
        next_target     = target_q;
        next_jr_pending = jr_pending;
        next_jr_stall   = jr_stall_q;
        fire            = 1'b0;
        fire_pc         = target_q;
        mis_inc         = 1'b0;
        decode_ok       = !flush_q;

        if (bus.mispredict_valid && (state != ST_WAIT_RECOVER)) begin
            next_state      = ST_WAIT_RECOVER;
            next_target     = bus.mispredict_target;
            next_jr_pending = 1'b0;
            next_jr_stall   = 1'b0;
            mis_inc         = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (decode_ok && bus.dec_redir_valid) begin
                        next_target = bus.dec_redir_target;
                        next_state  = ST_WAIT_SLOT;
                    end else if (decode_ok && bus.dec_jr_valid) begin
                        next_state = ST_WAIT_SLOT_JR;
                    end
                end
                ST_WAIT_SLOT: begin
                    if (decode_ok && bus.slot_accept) begin
                        fire = 1'b1;
                    end
                end
                ST_WAIT_SLOT_JR: begin
                    if (bus.jr_commit_valid) begin
                        next_target     = bus.jr_commit_target;
                        next_jr_pending = 1'b1;
                    end
                    if (decode_ok && bus.slot_accept) begin
                        if (jr_pending) begin
                            fire = 1'b1;
                        end else if (bus.jr_commit_valid) begin
                            fire    = 1'b1;
                            fire_pc = bus.jr_commit_target;
                        end else begin
                            next_state    = ST_WAIT_JR_TARGET;
                            next_jr_stall = 1'b1;
                        end
                    end
                end
                ST_WAIT_JR_TARGET: begin
                    if (bus.jr_commit_valid) begin
                        fire          = 1'b1;
                        fire_pc       = bus.jr_commit_target;
                        next_jr_stall = 1'b0;
                    end
                end
                ST_WAIT_RECOVER: begin
                    if (bus.commit_valid) begin
                        fire = 1'b1;
                    end
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
            if (fire) begin
                next_state      = ST_IDLE;
                next_jr_pending = 1'b0;
            end
        end
    end

    // State and registered outputs; reset drops any pending redirect silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            target_q     <= '0;
            jr_pending   <= 1'b0;
            jr_stall_q   <= 1'b0;
            load_pc_we_q <= 1'b0;
            flush_q      <= 1'b0;
            new_pc_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            state        <= next_state;
            target_q     <= next_target;
            jr_pending   <= next_jr_pending;
            jr_stall_q   <= next_jr_stall;
            load_pc_we_q <= fire;
            flush_q      <= fire;
            busy_q       <= (next_state != ST_IDLE);
            if (fire) begin
                new_pc_q <= fire_pc;
            end
        end
    end

    assign bus.load_pc_we     = load_pc_we_q;
    assign bus.load_pc_new_pc = new_pc_q;
    assign bus.flush          = flush_q;
    assign bus.jr_stall       = jr_stall_q;
    assign bus.busy           = busy_q;

    stat_counter #(.WIDTH(CNT_WIDTH), .SATURATE(1'b0)) u_redirect_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (fire),
        .count (redirect_count)
    );

    stat_counter #(.WIDTH(CNT_WIDTH), .SATURATE(1'b1)) u_mispredict_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mis_inc),
        .count (mispredict_count)
    );
endmodule

// File: tb/tb_redirect_sequencer.sv
// Directed self-checking bench for redirect_sequencer; a second instance with
// 2-bit counters exercises wrap and saturation.
module tb_redirect_sequencer;
    import redirect_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] redirect_count, mispredict_count;
    logic [1:0]  redirect_count2, mispredict_count2;

    redirect_sequencer_if #(.ADDR_WIDTH(32)) bus ();
    redirect_sequencer_if #(.ADDR_WIDTH(32)) bus2 ();

    redirect_sequencer #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus.slave),
        .redirect_count   (redirect_count),
        .mispredict_count (mispredict_count)
    );

    redirect_sequencer #(.ADDR_WIDTH(32), .CNT_WIDTH(2)) dut2 (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus2.slave),
        .redirect_count   (redirect_count2),
        .mispredict_count (mispredict_count2)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and count the result.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs to both instances, clock it, then settle.
    task automatic applyStimulus(input logic dr, input logic [31:0] dt,
                                 input logic dj, input logic sa,
                                 input logic jc, input logic [31:0] jt,
                                 input logic mv, input logic [31:0] mt,
                                 input logic cv);
        bus.dec_redir_valid   = dr;  bus2.dec_redir_valid   = dr;
        bus.dec_redir_target  = dt;  bus2.dec_redir_target  = dt;
        bus.dec_jr_valid      = dj;  bus2.dec_jr_valid      = dj;
        bus.slot_accept       = sa;  bus2.slot_accept       = sa;
        bus.jr_commit_valid   = jc;  bus2.jr_commit_valid   = jc;
        bus.jr_commit_target  = jt;  bus2.jr_commit_target  = jt;
        bus.mispredict_valid  = mv;  bus2.mispredict_valid  = mv;
        bus.mispredict_target = mt;  bus2.mispredict_target = mt;
        bus.commit_valid      = cv;  bus2.commit_valid      = cv;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    endtask

    initial begin
        bus.dec_redir_valid = 0; bus.dec_redir_target = 0; bus.dec_jr_valid = 0;
        bus.slot_accept = 0; bus.jr_commit_valid = 0; bus.jr_commit_target = 0;
        bus.mispredict_valid = 0; bus.mispredict_target = 0; bus.commit_valid = 0;
        bus2.dec_redir_valid = 0; bus2.dec_redir_target = 0; bus2.dec_jr_valid = 0;
        bus2.slot_accept = 0; bus2.jr_commit_valid = 0; bus2.jr_commit_target = 0;
        bus2.mispredict_valid = 0; bus2.mispredict_target = 0; bus2.commit_valid = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_we", bus.load_pc_we, 0);
        checkOutput("rst_pc", bus.load_pc_new_pc, 0);
        checkOutput("rst_flush", bus.flush, 0);
        checkOutput("rst_stall", bus.jr_stall, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_rcnt", redirect_count, 0);
        checkOutput("rst_mcnt", mispredict_count, 0);
        @(negedge clk);
        rst = 1'b0;

        // Taken branch, slot accepted three cycles later
        applyStimulus(1, 32'h0040_0100, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("br_busy", bus.busy, 1);
        checkOutput("br_we_early", bus.load_pc_we, 0);
        idleCycle();
        idleCycle();
        checkOutput("br_we_wait", bus.load_pc_we, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("br_we", bus.load_pc_we, 1);
        checkOutput("br_flush", bus.flush, 1);
        checkOutput("br_pc", bus.load_pc_new_pc, 32'h0040_0100);
        checkOutput("br_rcnt", redirect_count, 1);
        idleCycle();
        checkOutput("br_we_off", bus.load_pc_we, 0);
        checkOutput("br_busy_off", bus.busy, 0);

        // slot_accept alongside the branch itself is not the delay slot
        applyStimulus(1, 32'h0040_0180, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("own_we", bus.load_pc_we, 0);
        idleCycle();
        checkOutput("own_busy", bus.busy, 1);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("own_we2", bus.load_pc_we, 1);
        checkOutput("own_pc", bus.load_pc_new_pc, 32'h0040_0180);

        // Decode request during the flush cycle is dropped
        applyStimulus(1, 32'h0040_0999, 1, 1, 0, 0, 0, 0, 0);
        checkOutput("mask_busy", bus.busy, 0);
        checkOutput("mask_we", bus.load_pc_we, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("mask_we2", bus.load_pc_we, 0);
        checkOutput("mask_rcnt", redirect_count, 2);

        // JR with late target: stall until commit
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("jrl_busy", bus.busy, 1);
        checkOutput("jrl_stall0", bus.jr_stall, 0);
        idleCycle();
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("jrl_stall1", bus.jr_stall, 1);
        for (int i = 0; i < 6; i++) idleCycle();
        checkOutput("jrl_stall_hold", bus.jr_stall, 1);
        checkOutput("jrl_we_hold", bus.load_pc_we, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h0040_2000, 0, 0, 0);
        checkOutput("jrl_we", bus.load_pc_we, 1);
        checkOutput("jrl_pc", bus.load_pc_new_pc, 32'h0040_2000);
        checkOutput("jrl_stall_fall", bus.jr_stall, 0);
        idleCycle();
        checkOutput("jrl_we_off", bus.load_pc_we, 0);

        // JR with target resolved before the slot
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        idleCycle();
        applyStimulus(0, 0, 0, 0, 1, 32'h0040_3000, 0, 0, 0);
        checkOutput("jre_stall", bus.jr_stall, 0);
        checkOutput("jre_we_early", bus.load_pc_we, 0);
        idleCycle();
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("jre_we", bus.load_pc_we, 1);
        checkOutput("jre_pc", bus.load_pc_new_pc, 32'h0040_3000);
        checkOutput("jre_stall2", bus.jr_stall, 0);
        idleCycle();

        // JR target and slot in the same cycle
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 32'h0040_4000, 0, 0, 0);
        checkOutput("jrs_we", bus.load_pc_we, 1);
        checkOutput("jrs_pc", bus.load_pc_new_pc, 32'h0040_4000);
        checkOutput("jrs_stall", bus.jr_stall, 0);
        idleCycle();

        // Mispredict preempts a pending branch; same-cycle commit ignored
        applyStimulus(1, 32'h0040_0200, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h0040_0444, 1);
        checkOutput("mp_we0", bus.load_pc_we, 0);
        checkOutput("mp_mcnt", mispredict_count, 1);
        checkOutput("mp_busy", bus.busy, 1);
        applyStimulus(0, 0, 0, 1, 0, 0, 1, 32'h0040_0888, 0);
        checkOutput("mp_we1", bus.load_pc_we, 0);
        checkOutput("mp_mcnt_hold", mispredict_count, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("mp_we", bus.load_pc_we, 1);
        checkOutput("mp_pc", bus.load_pc_new_pc, 32'h0040_0444);
        checkOutput("mp_rcnt", redirect_count, 6);
        idleCycle();
        checkOutput("mp_we_off", bus.load_pc_we, 0);
        checkOutput("mp_busy_off", bus.busy, 0);

        // Asynchronous reset while waiting for the jr target
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        idleCycle();
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("ar_stall_pre", bus.jr_stall, 1);
        bus.slot_accept = 0; bus2.slot_accept = 0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("ar_stall", bus.jr_stall, 0);
        checkOutput("ar_busy", bus.busy, 0);
        checkOutput("ar_rcnt", redirect_count, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 1, 32'h0040_5000, 0, 0, 0);
        idleCycle();
        checkOutput("ar_we", bus.load_pc_we, 0);
        checkOutput("ar_busy2", bus.busy, 0);

        // Five mispredicts: 2-bit mispredict counter saturates, redirect wraps
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h0041_0000 + 32'(i), 0);
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
            idleCycle();
        end
        checkOutput("sat_mcnt2", mispredict_count2, 3);
        checkOutput("sat_rcnt2", redirect_count2, 1);
        checkOutput("sat_mcnt", mispredict_count, 5);
        checkOutput("sat_pc2", bus2.load_pc_new_pc, 32'h0041_0004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
